tw_addr_seq: RTL and testbench

- Sequencer that drives the twiddle ROM address for a radix-2 DIF FFT: walks every stage and every butterfly of an N-point transform, one butterfly per accepted beat.
- Sits between the FFT top-level controller (start/done) and the butterfly unit. The butterfly unit consumes {tw_addr, stage, bfly_idx} through a valid/ready handshake, and tw_addr feeds the asynchronous twiddle ROM directly.

---
 rtl/fft_pkg.sv | 23 ++
 rtl/tw_addr_map.sv | 46 ++++
 rtl/tw_addr_seq.sv | 139 +++++++++++++
 tb/tb_tw_addr_seq.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types and width helpers for the FFT twiddle address sequencer.
package fft_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_t;

  function automatic int calc_l_stages(input int n);
    return $clog2(n);
  endfunction

  function automatic int calc_a_width(input int n);
    return $clog2(n / 2);
  endfunction

  // A single-stage count still needs one bit to carry the stage number.
  function automatic int calc_s_width(input int n);
    return ($clog2($clog2(n)) < 1) ? 1 : $clog2($clog2(n));
  endfunction

endpackage

// File: rtl/tw_addr_map.sv
// Combinational (bfly_idx, stage) -> (tw_addr, rot_nj) mapping for radix-2 DIF.
// Optional quarter-wave ROM folding is enabled with TW_QUARTER_EN.
module tw_addr_map
  import fft_pkg::*;
#(
  parameter int N_POINTS = 8,
  parameter int A_WIDTH  = calc_a_width(N_POINTS),
  parameter int S_WIDTH  = calc_s_width(N_POINTS)
) (
  input  logic [A_WIDTH-1:0] i_bfly_idx,
  input  logic [S_WIDTH-1:0] i_stage,
  output logic [A_WIDTH-1:0] o_tw_addr,
  output logic               o_rot_nj
);

  localparam logic [A_WIDTH:0] HALF     = (A_WIDTH + 1)'(N_POINTS / 2);
  localparam logic [A_WIDTH:0] SPAN_ONE = (A_WIDTH + 1)'(1);

  logic [A_WIDTH:0]   w_span;
  logic [A_WIDTH-1:0] w_mask;
  logic [A_WIDTH-1:0] w_raw;

  // mod by a power of two is a mask; N/2 itself yields an all-ones mask
  assign w_span = HALF >> i_stage;
  assign w_mask = A_WIDTH'(w_span - SPAN_ONE);
  assign w_raw  = (i_bfly_idx & w_mask) << i_stage;

`ifdef TW_QUARTER_EN
  localparam logic [A_WIDTH-1:0] QUARTER = A_WIDTH'(N_POINTS / 4);

  always_comb begin
    o_tw_addr = w_raw;
    o_rot_nj  = 1'b0;
    if (w_raw >= QUARTER) begin
      o_tw_addr = w_raw - QUARTER;
      o_rot_nj  = 1'b1;
    end
  end
`else
  always_comb begin
    o_tw_addr = w_raw;
    o_rot_nj  = 1'b0;
  end
`endif

endmodule

// File: rtl/tw_addr_seq.sv
// Twiddle ROM address sequencer: one butterfly beat per valid/ready transfer
// across all stages of an N-point radix-2 DIF FFT. Honours TW_QUARTER_EN.
//
// state   | meaning
// IDLE    | waiting for start, outputs quiet
// RUN     | presenting beats, advancing on out_valid & out_ready
// DONE    | one-cycle done pulse, busy still high
module tw_addr_seq
  import fft_pkg::*;
#(
  parameter int N_POINTS = 8,
  parameter int L_STAGES = calc_l_stages(N_POINTS),
  parameter int A_WIDTH  = calc_a_width(N_POINTS),
  parameter int S_WIDTH  = calc_s_width(N_POINTS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [A_WIDTH-1:0] tw_addr,
  output logic [S_WIDTH-1:0] stage,
  output logic [A_WIDTH-1:0] bfly_idx,
  output logic               last,
  output logic               rot_nj,
  output logic               busy,
  output logic               done
);

  localparam logic [A_WIDTH-1:0] IDX_MAX   = A_WIDTH'(N_POINTS / 2 - 1);
  localparam logic [S_WIDTH-1:0] STAGE_MAX = S_WIDTH'(L_STAGES - 1);
  localparam logic [A_WIDTH-1:0] ONE_A     = A_WIDTH'(1);
  localparam logic [S_WIDTH-1:0] ONE_S     = S_WIDTH'(1);

  seq_state_t         r_state;
  logic               r_valid;
  logic [A_WIDTH-1:0] r_tw;
  logic [S_WIDTH-1:0] r_stage;
  logic [A_WIDTH-1:0] r_idx;
  logic               r_last;
  logic               r_rot;
  logic               r_busy;
  logic               r_done;

  logic               w_accept;
  logic               w_wrap;
  logic [A_WIDTH-1:0] w_nxt_idx;
  logic [S_WIDTH-1:0] w_nxt_stage;
  logic [A_WIDTH-1:0] w_nxt_tw;
  logic               w_nxt_rot;

  assign w_accept    = r_valid & out_ready;
  assign w_wrap      = (r_idx == IDX_MAX);
  assign w_nxt_idx   = w_wrap ? '0 : r_idx + ONE_A;
  assign w_nxt_stage = w_wrap ? r_stage + ONE_S : r_stage;

  // address of the following beat is mapped ahead so tw_addr can be registered
  tw_addr_map #(
    .N_POINTS (N_POINTS),
    .A_WIDTH  (A_WIDTH),
    .S_WIDTH  (S_WIDTH)
  ) u_map (
    .i_bfly_idx (w_nxt_idx),
    .i_stage    (w_nxt_stage),
    .o_tw_addr  (w_nxt_tw),
    .o_rot_nj   (w_nxt_rot)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_valid <= 1'b0;
      r_tw    <= '0;
      r_stage <= '0;
      r_idx   <= '0;
      r_last  <= 1'b0;
      r_rot   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state <= ST_RUN;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            r_tw    <= '0;
            r_stage <= '0;
            r_idx   <= '0;
            r_last  <= 1'b0;
            r_rot   <= 1'b0;
          end
        end
        ST_RUN: begin
          if (w_accept) begin
            if (r_last) begin
              r_state <= ST_DONE;
              r_valid <= 1'b0;
              r_done  <= 1'b1;
              r_tw    <= '0;
              r_stage <= '0;
              r_idx   <= '0;
              r_last  <= 1'b0;
              r_rot   <= 1'b0;
            end else begin
              r_idx   <= w_nxt_idx;
              r_stage <= w_nxt_stage;
              r_tw    <= w_nxt_tw;
              r_rot   <= w_nxt_rot;
              r_last  <= (w_nxt_stage == STAGE_MAX) && (w_nxt_idx == IDX_MAX);
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = r_valid;
  assign tw_addr   = r_tw;
  assign stage     = r_stage;
  assign bfly_idx  = r_idx;
  assign last      = r_last;
  assign rot_nj    = r_rot;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_tw_addr_seq.sv
// Self-checking bench for tw_addr_seq at N=8 and N=16 against an arithmetic model.
module tb_tw_addr_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst8 = 1'b1, start8 = 1'b0, ready8 = 1'b0;
  logic       v8, last8, rot8, busy8, done8;
  logic [1:0] tw8, st8, ix8;

  logic       rst16 = 1'b1, start16 = 1'b0, ready16 = 1'b0;
  logic       v16, last16, rot16, busy16, done16;
  logic [2:0] tw16, ix16;
  logic [1:0] st16;

  int n_pass = 0;
  int n_total = 0;

  tw_addr_seq #(.N_POINTS(8)) dut8 (
    .clk(clk), .rst(rst8), .start(start8), .out_ready(ready8),
    .out_valid(v8), .tw_addr(tw8), .stage(st8), .bfly_idx(ix8),
    .last(last8), .rot_nj(rot8), .busy(busy8), .done(done8)
  );

  tw_addr_seq #(.N_POINTS(16)) dut16 (
    .clk(clk), .rst(rst16), .start(start16), .out_ready(ready16),
    .out_valid(v16), .tw_addr(tw16), .stage(st16), .bfly_idx(ix16),
    .last(last16), .rot_nj(rot16), .busy(busy16), .done(done16)
  );

  // Beat k of an n-point pass, straight from the address rule.
  function automatic void model(input int n, input int k, output int st, output int ix,
                                output int tw, output int rot, output int lst);
    int half;
    int raw;
    half = n / 2;
    st   = k / half;
    ix   = k % half;
    raw  = (ix % (half >> st)) << st;
    tw   = raw;
    rot  = 0;
`ifdef TW_QUARTER_EN
    if (raw >= n / 4) begin
      tw  = raw - n / 4;
      rot = 1;
    end
`endif
    lst = (k == $clog2(n) * half - 1) ? 1 : 0;
  endfunction

  task automatic test_reset();
    @(negedge clk);
    n_total++;
    if ({v8, tw8, st8, ix8, last8, rot8, busy8, done8} !== 12'd0 ||
        {v16, tw16, st16, ix16, last16, rot16, busy16, done16} !== 14'd0) begin
      $display("FAIL reset: got dut8=%b dut16=%b required all zero",
               {v8, tw8, st8, ix8, last8, rot8, busy8, done8},
               {v16, tw16, st16, ix16, last16, rot16, busy16, done16});
    end else n_pass++;
    rst8 = 1'b0;
    rst16 = 1'b0;
    @(negedge clk);
  endtask

  // mode 0: ready held high, 1: 3-cycle stall on beat 5, 2: start toggled during the pass
  task automatic run_pass8(input int mode, input string name);
    int beats, cyc, stall, early_done;
    int st, ix, tw, rot, lst;
    beats = 0; cyc = 0; stall = 0; early_done = 0;
    start8 = 1'b1;
    ready8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    n_total++;
    if (v8 !== 1'b1 || busy8 !== 1'b1) begin
      $display("FAIL %s first_valid: got valid=%b busy=%b required 1 1", name, v8, busy8);
    end else n_pass++;
    while (beats < 12 && cyc < 60) begin
      if (done8 === 1'b1) early_done++;
      ready8 = 1'b1;
      if (mode == 1 && beats == 4 && stall < 3) begin
        ready8 = 1'b0;
        stall++;
      end
      if (mode == 2) start8 = (cyc % 2 == 0);
      model(8, beats, st, ix, tw, rot, lst);
      n_total++;
      if (v8 !== 1'b1 || int'(st8) !== st || int'(ix8) !== ix || int'(tw8) !== tw ||
          int'(rot8) !== rot || int'(last8) !== lst || busy8 !== 1'b1) begin
        $display("FAIL %s beat%0d: got v=%b st=%0d ix=%0d tw=%0d rot=%0d last=%0d busy=%b required v=1 st=%0d ix=%0d tw=%0d rot=%0d last=%0d busy=1",
                 name, beats + 1, v8, st8, ix8, tw8, rot8, last8, busy8, st, ix, tw, rot, lst);
      end else n_pass++;
      if (v8 === 1'b1 && ready8) beats++;
      @(negedge clk);
      cyc++;
    end
    start8 = 1'b0;
    ready8 = 1'b1;
    n_total++;
    if (beats != 12 || early_done != 0) begin
      $display("FAIL %s beat_count: got %0d beats early_done=%0d required 12 beats 0", name, beats, early_done);
    end else n_pass++;
    n_total++;
    if (done8 !== 1'b1 || v8 !== 1'b0 || busy8 !== 1'b1) begin
      $display("FAIL %s done_pulse: got done=%b valid=%b busy=%b required 1 0 1", name, done8, v8, busy8);
    end else n_pass++;
    @(negedge clk);
    n_total++;
    if (done8 !== 1'b0 || busy8 !== 1'b0 || v8 !== 1'b0) begin
      $display("FAIL %s idle_return: got done=%b busy=%b valid=%b required 0 0 0", name, done8, busy8, v8);
    end else n_pass++;
    if (mode == 2) begin
      repeat (3) @(negedge clk);
      n_total++;
      if (v8 !== 1'b0 || busy8 !== 1'b0 || done8 !== 1'b0) begin
        $display("FAIL %s no_restart: got valid=%b busy=%b done=%b required 0 0 0", name, v8, busy8, done8);
      end else n_pass++;
    end
  endtask

  task automatic test_nominal();
    run_pass8(0, "nominal");
  endtask

  task automatic test_backpressure();
    run_pass8(1, "backpressure");
  endtask

  task automatic test_start_ignored();
    run_pass8(2, "start_ignored");
  endtask

  task automatic test_rst_midpass();
    int beats, cyc, dones;
    int st, ix, tw, rot, lst;
    beats = 0; cyc = 0; dones = 0;
    start8 = 1'b1;
    ready8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    while (beats < 6 && cyc < 30) begin
      if (v8 === 1'b1) beats++;
      @(negedge clk);
      cyc++;
    end
    model(8, 6, st, ix, tw, rot, lst);
    n_total++;
    if (v8 !== 1'b1 || int'(st8) !== st || int'(ix8) !== ix || int'(tw8) !== tw) begin
      $display("FAIL rst_midpass beat7: got v=%b st=%0d ix=%0d tw=%0d required v=1 st=%0d ix=%0d tw=%0d",
               v8, st8, ix8, tw8, st, ix, tw);
    end else n_pass++;
    rst8 = 1'b1;
    #1;
    n_total++;
    if ({v8, tw8, st8, ix8, last8, rot8, busy8, done8} !== 12'd0) begin
      $display("FAIL rst_midpass async_clear: got %b required all zero",
               {v8, tw8, st8, ix8, last8, rot8, busy8, done8});
    end else n_pass++;
    @(negedge clk);
    @(negedge clk);
    rst8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_total++;
    if (done8 !== 1'b0 || v8 !== 1'b0 || busy8 !== 1'b0) begin
      $display("FAIL rst_midpass no_done: got done=%b valid=%b busy=%b required 0 0 0", done8, v8, busy8);
    end else n_pass++;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    n_total++;
    if (v8 !== 1'b1 || st8 !== 2'd0 || ix8 !== 2'd0 || tw8 !== 2'd0) begin
      $display("FAIL rst_midpass restart: got v=%b st=%0d ix=%0d tw=%0d required 1 0 0 0", v8, st8, ix8, tw8);
    end else n_pass++;
    beats = 0;
    cyc = 0;
    while (dones == 0 && cyc < 40) begin
      if (v8 === 1'b1) beats++;
      @(negedge clk);
      cyc++;
      if (done8 === 1'b1) dones++;
    end
    n_total++;
    if (beats != 12 || dones != 1) begin
      $display("FAIL rst_midpass full_pass: got beats=%0d done=%0d required 12 1", beats, dones);
    end else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_random16();
    int beats, cyc, early_done;
    int st, ix, tw, rot, lst;
    beats = 0; cyc = 0; early_done = 0;
    start16 = 1'b1;
    ready16 = 1'b0;
    @(negedge clk);
    start16 = 1'b0;
    while (beats < 32 && cyc < 500) begin
      if (done16 === 1'b1) early_done++;
      ready16 = 1'($urandom_range(0, 1));
      model(16, beats, st, ix, tw, rot, lst);
      n_total++;
      if (v16 !== 1'b1 || int'(st16) !== st || int'(ix16) !== ix || int'(tw16) !== tw ||
          int'(rot16) !== rot || int'(last16) !== lst) begin
        $display("FAIL random16 beat%0d: got v=%b st=%0d ix=%0d tw=%0d rot=%0d last=%0d required v=1 st=%0d ix=%0d tw=%0d rot=%0d last=%0d",
                 beats + 1, v16, st16, ix16, tw16, rot16, last16, st, ix, tw, rot, lst);
      end else n_pass++;
      if (v16 === 1'b1 && ready16) beats++;
      @(negedge clk);
      cyc++;
    end
    ready16 = 1'b0;
    n_total++;
    if (beats != 32 || early_done != 0) begin
      $display("FAIL random16 beat_count: got %0d beats early_done=%0d required 32 0", beats, early_done);
    end else n_pass++;
    n_total++;
    if (done16 !== 1'b1 || v16 !== 1'b0 || busy16 !== 1'b1) begin
      $display("FAIL random16 done_pulse: got done=%b valid=%b busy=%b required 1 0 1", done16, v16, busy16);
    end else n_pass++;
    @(negedge clk);
    n_total++;
    if (done16 !== 1'b0 || busy16 !== 1'b0) begin
      $display("FAIL random16 idle_return: got done=%b busy=%b required 0 0", done16, busy16);
    end else n_pass++;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_start_ignored();
    test_rst_midpass();
    test_random16();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
